// File: rtl/div_pkg.sv
// Shared types and constants for the divide sequencer (div_ctrl) and its helpers.
package div_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] DIV_OP  = 2'b00;
    localparam logic [1:0] DIVU_OP = 2'b01;
    localparam logic [1:0] REM_OP  = 2'b10;
    localparam logic [1:0] REMU_OP = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_DRAIN,
        S_RESP
    } state_e;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    // funct3[0] clear selects the signed variants (DIV/REM)
    function automatic logic op_is_signed(input logic [1:0] op);
        return !op[0];
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_special.sv
// Combinational detector for RISC-V divide-by-zero and signed-overflow cases,
// which are answered without running the iterative divider.
module div_special
    import div_pkg::*;
(
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            signed_i,
    output logic            special_o,
    output logic [XLEN-1:0] quot_o,
    output logic [XLEN-1:0] rem_o
);

    logic div_zero;
    logic overflow;

    assign div_zero = (b_i == '0);
    assign overflow = signed_i && (a_i == INT_MIN) && (b_i == ALL_ONES);

    always_comb begin
        special_o = 1'b0;
        quot_o    = '0;
        rem_o     = '0;
        if (div_zero) begin
            special_o = 1'b1;
            quot_o    = ALL_ONES;
            rem_o     = a_i;
        end else if (overflow) begin
            special_o = 1'b1;
            quot_o    = a_i;
            rem_o     = '0;
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Sequencer between EX and the shared iterative divider: special-case bypass,
// launch/hold/complete, flush and drain. Optional result cache: DIV_CACHE_EN.
module div_ctrl
    import div_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [1:0]      req_op_i,
    input  logic [XLEN-1:0] req_a_i,
    input  logic [XLEN-1:0] req_b_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_data_o,
    output logic [4:0]      resp_rd_o,
    output logic            busy_o,
    output logic            div_start_o,
    output logic [XLEN-1:0] div_dividend_o,
    output logic [XLEN-1:0] div_divisor_o,
    output logic            div_signed_o,
    input  logic            div_done_i,
    input  logic [XLEN-1:0] div_quot_i,
    input  logic [XLEN-1:0] div_rem_i
);

    state_e          state_q;
    logic [1:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] dividend_q;
    logic [XLEN-1:0] divisor_q;
    logic            signed_q;
    logic            start_q;
    logic            busy_q;
    logic            resp_valid_q;
    logic [XLEN-1:0] resp_data_q;
    logic [4:0]      resp_rd_q;

    logic            req_fire;
    logic            req_signed;
    logic            sp_special;
    logic [XLEN-1:0] sp_quot;
    logic [XLEN-1:0] sp_rem;
    logic            hit;
    logic [XLEN-1:0] hit_quot;
    logic [XLEN-1:0] hit_rem;
    logic [XLEN-1:0] fast_data_d;
    logic [XLEN-1:0] div_data_d;
    logic            div_fill;

    assign req_ready_o = (state_q == S_IDLE) && !flush_i && !rst;
    assign req_fire    = req_valid_i && req_ready_o;
    assign req_signed  = op_is_signed(req_op_i);

    div_special u_special (
        .a_i       (req_a_i),
        .b_i       (req_b_i),
        .signed_i  (req_signed),
        .special_o (sp_special),
        .quot_o    (sp_quot),
        .rem_o     (sp_rem)
    );

    // A completion that is not flushed in the same cycle is the only one that reaches RESP
    assign div_fill = (state_q == S_BUSY) && div_done_i && !flush_i;

`ifdef DIV_CACHE_EN
    logic            cache_vld_q;
    logic            cache_signed_q;
    logic [XLEN-1:0] cache_a_q;
    logic [XLEN-1:0] cache_b_q;
    logic [XLEN-1:0] cache_quot_q;
    logic [XLEN-1:0] cache_rem_q;

    assign hit      = cache_vld_q && (cache_a_q == req_a_i) && (cache_b_q == req_b_i)
                      && (cache_signed_q == req_signed);
    assign hit_quot = cache_quot_q;
    assign hit_rem  = cache_rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cache_vld_q <= 1'b0;
        end else if (div_fill) begin
            cache_vld_q    <= 1'b1;
            cache_signed_q <= signed_q;
            cache_a_q      <= dividend_q;
            cache_b_q      <= divisor_q;
            cache_quot_q   <= div_quot_i;
            cache_rem_q    <= div_rem_i;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_quot = '0;
    assign hit_rem  = '0;
`endif

    // Special cases take priority over a cache hit; both answer in one cycle
    assign fast_data_d = sp_special ? (op_is_rem(req_op_i) ? sp_rem  : sp_quot)
                                    : (op_is_rem(req_op_i) ? hit_rem : hit_quot);
    assign div_data_d  = op_is_rem(op_q) ? div_rem_i : div_quot_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            rd_q         <= '0;
            dividend_q   <= '0;
            divisor_q    <= '0;
            signed_q     <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_rd_q    <= '0;
        end else begin
            start_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_fire) begin
                        op_q       <= req_op_i;
                        rd_q       <= req_rd_i;
                        dividend_q <= req_a_i;
                        divisor_q  <= req_b_i;
                        signed_q   <= req_signed;
                        busy_q     <= 1'b1;
                        if (sp_special || hit) begin
                            resp_valid_q <= 1'b1;
                            resp_data_q  <= fast_data_d;
                            resp_rd_q    <= req_rd_i;
                            state_q      <= S_RESP;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= S_START;
                        end
                    end
                end
                // The launch pulse is already out, so a flush here must still drain
                S_START: begin
                    state_q <= flush_i ? S_DRAIN : S_BUSY;
                end
                S_BUSY: begin
                    if (div_done_i && flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (div_done_i) begin
                        resp_valid_q <= 1'b1;
                        resp_data_q  <= div_data_d;
                        resp_rd_q    <= rd_q;
                        state_q      <= S_RESP;
                    end else if (flush_i) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (div_done_i) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid_o   = resp_valid_q;
    assign resp_data_o    = resp_data_q;
    assign resp_rd_o      = resp_rd_q;
    assign busy_o         = busy_q;
    assign div_start_o    = start_q;
    assign div_dividend_o = dividend_q;
    assign div_divisor_o  = divisor_q;
    assign div_signed_o   = signed_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: random RV32M divide traffic against a
// behavioural divider/result model, plus directed flush and reset scenarios.
module tb_div_ctrl;
    import div_pkg::*;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        resp_valid_o;
    logic [31:0] resp_data_o;
    logic [4:0]  resp_rd_o;
    logic        busy_o;
    logic        div_start_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic        div_signed_o;
    logic        div_done_i;
    logic [31:0] div_quot_i;
    logic [31:0] div_rem_i;

    div_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_op_i       (req_op_i),
        .req_a_i        (req_a_i),
        .req_b_i        (req_b_i),
        .req_rd_i       (req_rd_i),
        .flush_i        (flush_i),
        .resp_valid_o   (resp_valid_o),
        .resp_data_o    (resp_data_o),
        .resp_rd_o      (resp_rd_o),
        .busy_o         (busy_o),
        .div_start_o    (div_start_o),
        .div_dividend_o (div_dividend_o),
        .div_divisor_o  (div_divisor_o),
        .div_signed_o   (div_signed_o),
        .div_done_i     (div_done_i),
        .div_quot_i     (div_quot_i),
        .div_rem_i      (div_rem_i)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        bit          fast;
        int          rcyc;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
    } st_t;

    exp_t sb[$];
    st_t  start_q[$];
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   lat_force;
    bit   inject;
    int   done_cyc;

`ifdef DIV_CACHE_EN
    bit          c_valid;
    logic [31:0] c_a;
    logic [31:0] c_b;
    bit          c_s;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // RISC-V division semantics from plain arithmetic: returns {quotient, remainder}
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int          sa;
        int          dv;
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'h0) return {32'hFFFF_FFFF, a};
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, 32'h0};
        if (sgn) begin
            sa = a;
            dv = b;
            q  = sa / dv;
            r  = sa % dv;
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Behavioural external divider: latches operands on start, answers after a latency
    logic        m_pend;
    int          m_cnt;
    logic [31:0] m_a;
    logic [31:0] m_b;
    bit          m_s;
    initial begin
        logic [63:0] qr;
        st_t         s;
        m_pend     = 1'b0;
        m_cnt      = 0;
        div_done_i = 1'b0;
        div_quot_i = '0;
        div_rem_i  = '0;
        forever begin
            @(negedge clk);
            div_done_i = 1'b0;
            if (rst) begin
                m_pend = 1'b0;
            end else begin
                if (inject) begin
                    div_done_i = 1'b1;
                    div_quot_i = 32'hDEAD_0001;
                    div_rem_i  = 32'hDEAD_0002;
                    inject     = 1'b0;
                end
                if (m_pend) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_pend     = 1'b0;
                        qr         = ref_div(m_a, m_b, m_s);
                        div_quot_i = qr[63:32];
                        div_rem_i  = qr[31:0];
                        div_done_i = 1'b1;
                        done_cyc   = cyc;
                        check("dividend_held", div_dividend_o, m_a);
                        check("divisor_held", div_divisor_o, m_b);
                    end
                end
                if (div_start_o) begin
                    if (start_q.size() == 0) begin
                        check("unexpected_start", 32'd1, 32'd0);
                    end else begin
                        s = start_q.pop_front();
                        check("start_cycle", cyc, s.cyc);
                        check("start_dividend", div_dividend_o, s.a);
                        check("start_divisor", div_divisor_o, s.b);
                        check("start_signed", {31'd0, div_signed_o}, {31'd0, s.sgn});
                    end
                    m_pend = 1'b1;
                    m_a    = div_dividend_o;
                    m_b    = div_divisor_o;
                    m_s    = div_signed_o;
                    m_cnt  = (lat_force > 0) ? lat_force : int'($urandom_range(1, 5));
                end
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the DUT presents a result
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", resp_data_o, e.data);
                    check("resp_rd", {27'd0, resp_rd_o}, {27'd0, e.rd});
                    if (e.fast) check("fast_latency", cyc, e.rcyc);
                    else        check("div_latency", cyc, done_cyc + 1);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first cycle after acceptance
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit track);
        bit          acc;
        int          guard;
        bit          sgn;
        bit          special;
        bit          hit;
        logic [63:0] qr;
        exp_t        e;
        st_t         s;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_a_i     = a;
        req_b_i     = b;
        req_rd_i    = rd;
        acc         = 1'b0;
        guard       = 0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = req_ready_o;
            @(posedge clk);
            #1;
            guard++;
        end
        req_valid_i = 1'b0;
        if (!acc) begin
            check("accept_timeout", 32'd0, 32'd1);
            return;
        end
        sgn     = !op[0];
        special = (b == 32'h0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        hit     = 1'b0;
`ifdef DIV_CACHE_EN
        hit = !special && c_valid && c_a == a && c_b == b && c_s == sgn;
`endif
        qr = ref_div(a, b, sgn);
        if (!special && !hit) begin
            s.cyc = cyc;
            s.a   = a;
            s.b   = b;
            s.sgn = sgn;
            start_q.push_back(s);
`ifdef DIV_CACHE_EN
            if (track) begin
                c_valid = 1'b1;
                c_a     = a;
                c_b     = b;
                c_s     = sgn;
            end
`endif
        end
        if (track) begin
            e.data = op[1] ? qr[31:0] : qr[63:32];
            e.rd   = rd;
            e.fast = special || hit;
            e.rcyc = cyc;
            sb.push_back(e);
        end
    endtask

    function automatic logic [31:0] pick_a();
        case ($urandom_range(0, 3))
            0:       return 32'h8000_0000;
            1:       return $urandom;
            2:       return $urandom_range(0, 100);
            default: return -$urandom_range(1, 100);
        endcase
    endfunction

    function automatic logic [31:0] pick_b();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return $urandom_range(1, 20);
            3:       return $urandom;
            default: return 32'h1;
        endcase
    endfunction

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          seen;
        n_checks    = 0;
        n_pass      = 0;
        lat_force   = 0;
        inject      = 1'b0;
        done_cyc    = -100;
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_op_i    = '0;
        req_a_i     = '0;
        req_b_i     = '0;
        req_rd_i    = '0;
        flush_i     = 1'b0;
`ifdef DIV_CACHE_EN
        c_valid = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", {31'd0, req_ready_o}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_start", {31'd0, div_start_o}, 32'd0);
        check("rst_dividend", div_dividend_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk);
        #1;

        issue(DIVU_OP, 32'd100, 32'd7, 5'd1, 1'b1);
        issue(REMU_OP, 32'd100, 32'd7, 5'd2, 1'b1);
        issue(DIV_OP,  32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 1'b1);
        issue(REM_OP,  32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 1'b1);
        issue(DIVU_OP, 32'd5, 32'd0, 5'd5, 1'b1);
        issue(REM_OP,  32'd5, 32'd0, 5'd6, 1'b1);
        issue(DIV_OP,  -32'sd7, 32'd2, 5'd7, 1'b1);
        issue(REM_OP,  -32'sd7, 32'd2, 5'd8, 1'b1);

        // Flush two cycles after launch: no response, ready returns only after the drain
        lat_force = 8;
        issue(DIVU_OP, 32'd1000, 32'd7, 5'd9, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #2;
            if (div_done_i) begin
                check("ready_after_drain", {31'd0, req_ready_o}, 32'd1);
                seen = 1'b1;
            end else begin
                check("ready_in_drain", {31'd0, req_ready_o}, 32'd0);
            end
        end
        if (!seen) check("drain_timeout", 32'd0, 32'd1);
        lat_force = 0;
        @(posedge clk);
        #1;

        // Reset while the divider is busy, then a stray completion in IDLE
        lat_force = 10;
        issue(DIVU_OP, 32'd77777, 32'd3, 5'd10, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #2;
        check("midrst_ready", {31'd0, req_ready_o}, 32'd0);
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_resp_valid", {31'd0, resp_valid_o}, 32'd0);
        check("midrst_resp_data", resp_data_o, 32'd0);
        check("midrst_resp_rd", {27'd0, resp_rd_o}, 32'd0);
        check("midrst_start", {31'd0, div_start_o}, 32'd0);
        check("midrst_dividend", div_dividend_o, 32'd0);
        check("midrst_divisor", div_divisor_o, 32'd0);
        check("midrst_signed", {31'd0, div_signed_o}, 32'd0);
        rst       = 1'b0;
        lat_force = 0;
`ifdef DIV_CACHE_EN
        c_valid = 1'b0;
`endif
        @(posedge clk);
        #1;
        inject = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        issue(DIVU_OP, 32'd9, 32'd3, 5'd11, 1'b1);

        ra = 32'd1;
        rb = 32'd1;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                ra = pick_a();
                rb = pick_b();
            end
            issue(2'($urandom_range(0, 3)), ra, rb, 5'($urandom_range(0, 31)), 1'b1);
        end

        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        check("sb_empty", sb.size(), 32'd0);
        check("start_q_empty", start_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
